// File: rtl/vram_rect_fill_pkg.sv
// Shared frame geometry, colour constants and fill FSM state encoding
// for the video memory rectangle fill engine.
package vram_rect_fill_pkg;

  localparam int unsigned COORD_WIDTH = 8;
  localparam int unsigned COLOR_WIDTH = 3;
  localparam int unsigned FB_WIDTH    = 256;
  localparam int unsigned FB_HEIGHT   = 256;

  // Colours are ordered {R,G,B}
  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vram_rect_fill_xy_scan.sv
// Loadable row-major column/row scan counter with stall and a last-pixel flag.
module vram_xy_scan #(
  parameter int unsigned COORD_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   advance,
  input  logic [COORD_WIDTH-1:0] x_start,
  input  logic [COORD_WIDTH-1:0] y_start,
  input  logic [COORD_WIDTH-1:0] x_end,
  input  logic [COORD_WIDTH-1:0] y_end,
  output logic [COORD_WIDTH-1:0] col,
  output logic [COORD_WIDTH-1:0] row,
  output logic                   last
);

  logic [COORD_WIDTH-1:0] x_first;
  logic [COORD_WIDTH-1:0] x_last;
  logic [COORD_WIDTH-1:0] y_last;

  always_comb begin
    last = (col == x_last) && (row == y_last);
  end

  // Counters never step past the latched end coordinates, so no wrap at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      x_first <= '0;
      x_last  <= '0;
      y_last  <= '0;
    end else if (load) begin
      col     <= x_start;
      row     <= y_start;
      x_first <= x_start;
      x_last  <= x_end;
      y_last  <= y_end;
    end else if (advance && !last) begin
      if (col == x_last) begin
        col <= x_first;
        row <= row + COORD_WIDTH'(1);
      end else begin
        col <= col + COORD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: clips a command to the frame and emits one
// registered pixel write per unstalled cycle, row-major.
module vram_rect_fill #(
  parameter int unsigned COORD_WIDTH = vram_rect_fill_pkg::COORD_WIDTH,
  parameter int unsigned COLOR_WIDTH = vram_rect_fill_pkg::COLOR_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iStart,
  input  logic [COORD_WIDTH-1:0]   iX,
  input  logic [COORD_WIDTH-1:0]   iY,
  input  logic [COORD_WIDTH:0]     iWidth,
  input  logic [COORD_WIDTH:0]     iHeight,
  input  logic [COLOR_WIDTH-1:0]   iColor,
  input  logic                     iStall,
  output logic                     oWriteEnable,
  output logic [2*COORD_WIDTH-1:0] oWriteAddress,
  output logic [COLOR_WIDTH-1:0]   oWriteColor,
  output logic                     oBusy,
  output logic                     oDone
);

  import vram_rect_fill_pkg::*;

  localparam int unsigned SW = COORD_WIDTH + 1;
  localparam logic [SW-1:0] FRAME = SW'(1) << COORD_WIDTH;

  fill_state_t            state;
  logic [COLOR_WIDTH-1:0] color_q;
  logic [SW-1:0]          span_w, span_h, weff, heff;
  logic [COORD_WIDTH-1:0] x_end, y_end, col, row;
  logic                   zero_area, accept, last;

  // Sizes clipped in 9-bit arithmetic; a full-width span (256) has low bits 0,
  // so the 8-bit end coordinate still wraps to 255 correctly.
  always_comb begin
    span_w    = FRAME - {1'b0, iX};
    span_h    = FRAME - {1'b0, iY};
    weff      = (iWidth  < span_w) ? iWidth  : span_w;
    heff      = (iHeight < span_h) ? iHeight : span_h;
    x_end     = iX + weff[COORD_WIDTH-1:0] - COORD_WIDTH'(1);
    y_end     = iY + heff[COORD_WIDTH-1:0] - COORD_WIDTH'(1);
    zero_area = (weff == '0) || (heff == '0);
    accept    = (state == IDLE) && iStart && !oDone;
  end

  vram_xy_scan #(.COORD_WIDTH(COORD_WIDTH)) u_scan (
    .clk     (Clock),
    .rst     (Reset),
    .load    (accept && !zero_area),
    .advance ((state == FILL) && !iStall),
    .x_start (iX),
    .y_start (iY),
    .x_end   (x_end),
    .y_end   (y_end),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      color_q       <= '0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oWriteColor   <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oDone        <= 1'b0;
          oWriteEnable <= 1'b0;
          if (accept) begin
            color_q <= iColor;
            // Zero-area commands pulse oDone straight from IDLE, never busy
            if (zero_area) begin
              oDone <= 1'b1;
            end else begin
              state <= FILL;
              oBusy <= 1'b1;
            end
          end
        end
        FILL: begin
          oWriteEnable  <= !iStall;
          oWriteAddress <= {row, col};
          oWriteColor   <= color_q;
          if (!iStall && last) begin
            state <= DONE;
          end
        end
        DONE: begin
          oWriteEnable <= 1'b0;
          oBusy        <= 1'b0;
          oDone        <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Self-checking bench for vram_rect_fill: command table plus hand-written
// stall, full-frame and reset sequences, with a write scoreboard.
module tb_vram_rect_fill;

  import vram_rect_fill_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iStart = 1'b0;
  logic [7:0]  iX = '0, iY = '0;
  logic [8:0]  iWidth = '0, iHeight = '0;
  logic [2:0]  iColor = '0;
  logic        iStall = 1'b0;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [2:0]  oWriteColor;
  logic        oBusy, oDone;

  int checks = 0;
  int errors = 0;
  int write_cnt = 0;

  typedef struct {
    int unsigned addr;
    logic [2:0]  color;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int unsigned x, y, w, h;
    logic [2:0]  color;
    int          exp_writes;
    int          exp_done;
  } vec_t;
  vec_t vecs[8];

  vram_rect_fill #(.COORD_WIDTH(8), .COLOR_WIDTH(3)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iStart        (iStart),
    .iX            (iX),
    .iY            (iY),
    .iWidth        (iWidth),
    .iHeight       (iHeight),
    .iColor        (iColor),
    .iStall        (iStall),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteColor   (oWriteColor),
    .oBusy         (oBusy),
    .oDone         (oDone)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oWriteEnable) begin
      wr_t e;
      write_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d color=%b, none expected", oWriteAddress, oWriteColor);
      end else begin
        e = exp_q.pop_front();
        if (oWriteAddress != 16'(e.addr) || oWriteColor != e.color) begin
          errors++;
          $display("FAIL write_data: got addr=%0d color=%b, want addr=%0d color=%b",
                   oWriteAddress, oWriteColor, e.addr, e.color);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_expected(input int unsigned x, y, w, h, input logic [2:0] c);
    int unsigned we, he;
    we = (w < 256 - x) ? w : 256 - x;
    he = (h < 256 - y) ? h : 256 - y;
    for (int unsigned r = 0; r < he; r++)
      for (int unsigned q = 0; q < we; q++)
        exp_q.push_back('{addr: (y + r) * 256 + (x + q), color: c});
  endtask

  // Cycle k=1 is the cycle right after the accepting edge.
  task automatic run_cmd(input int unsigned x, y, w, h, input logic [2:0] c,
                         input int stall_at, input int stall_len, input int hold_addr,
                         input int exp_writes, input int exp_done, input string name);
    int  done_k;
    int  busy_bad;
    logic stall_prev;
    done_k = -1;
    busy_bad = 0;
    stall_prev = 1'b0;
    push_expected(x, y, w, h, c);
    write_cnt = 0;
    @(negedge Clock);
    iX = 8'(x); iY = 8'(y); iWidth = 9'(w); iHeight = 9'(h); iColor = c;
    iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    for (int k = 1; k <= 70000; k++) begin
      @(negedge Clock);
      if (stall_prev) begin
        checks++;
        if (oWriteEnable !== 1'b0 || (hold_addr >= 0 && int'(oWriteAddress) != hold_addr)) begin
          errors++;
          $display("FAIL %s_stall_hold: we=%b addr=%0d, want we=0 addr=%0d",
                   name, oWriteEnable, oWriteAddress, hold_addr);
        end
      end
      stall_prev = (k >= stall_at) && (k < stall_at + stall_len);
      iStall = stall_prev;
      if (oDone) begin
        done_k = k;
        break;
      end
      if (oBusy !== (exp_done > 1)) busy_bad++;
    end
    iStall = 1'b0;
    check({name, "_done_cycle"}, done_k, exp_done);
    check({name, "_busy_at_done"}, int'(oBusy), 0);
    check({name, "_busy_profile"}, busy_bad, 0);
    check({name, "_write_count"}, write_cnt, exp_writes);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
    // iStart during the oDone cycle must be ignored
    iX = 8'd1; iY = 8'd1; iWidth = 9'd2; iHeight = 9'd2; iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    check({name, "_done_single"}, int'(oDone), 0);
    check({name, "_start_in_done_ignored"}, int'(oBusy), 0);
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    vecs[0] = '{x: 10,  y: 20,  w: 3,   h: 2,   color: RED,     exp_writes: 6,    exp_done: 8};
    vecs[1] = '{x: 254, y: 255, w: 10,  h: 5,   color: GREEN,   exp_writes: 2,    exp_done: 4};
    vecs[2] = '{x: 0,   y: 0,   w: 0,   h: 7,   color: BLUE,    exp_writes: 0,    exp_done: 1};
    vecs[3] = '{x: 5,   y: 5,   w: 1,   h: 1,   color: CYAN,    exp_writes: 1,    exp_done: 3};
    vecs[4] = '{x: 0,   y: 250, w: 4,   h: 256, color: MAGENTA, exp_writes: 24,   exp_done: 26};
    vecs[5] = '{x: 255, y: 0,   w: 256, h: 1,   color: YELLOW,  exp_writes: 1,    exp_done: 3};
    vecs[6] = '{x: 3,   y: 3,   w: 7,   h: 0,   color: WHITE,   exp_writes: 0,    exp_done: 1};
    vecs[7] = '{x: 200, y: 200, w: 256, h: 256, color: RED,     exp_writes: 3136, exp_done: 3138};

    #2;
    check("reset_we",   int'(oWriteEnable), 0);
    check("reset_addr", int'(oWriteAddress), 0);
    check("reset_busy", int'(oBusy), 0);
    check("reset_done", int'(oDone), 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
              0, 0, -1, vecs[i].exp_writes, vecs[i].exp_done, $sformatf("vec%0d", i));

    // 2x2 fill, stall held 3 cycles on the second pixel (40*256+31)
    run_cmd(30, 40, 2, 2, YELLOW, 2, 3, 10271, 4, 9, "stall");

    // Full frame with a stray iStart mid-fill
    fork
      run_cmd(0, 0, 256, 256, WHITE, 0, 0, -1, 65536, 65538, "full");
      begin
        repeat (1000) @(negedge Clock);
        iX = 8'd9; iY = 8'd9; iWidth = 9'd1; iHeight = 9'd1; iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
      end
    join

    // Reset during pixel 5 of a 4x4 fill
    push_expected(50, 60, 4, 4, GREEN);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    write_cnt = 0;
    @(negedge Clock);
    iX = 8'd50; iY = 8'd60; iWidth = 9'd4; iHeight = 9'd4; iColor = GREEN; iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    repeat (6) @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_we",    int'(oWriteEnable), 0);
    check("rst_mid_addr",  int'(oWriteAddress), 0);
    check("rst_mid_color", int'(oWriteColor), 0);
    check("rst_mid_busy",  int'(oBusy), 0);
    check("rst_mid_done",  int'(oDone), 0);
    check("rst_mid_writes", write_cnt, 5);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    begin
      int done_seen;
      done_seen = 0;
      repeat (8) begin
        @(negedge Clock);
        if (oDone) done_seen++;
      end
      check("rst_no_done", done_seen, 0);
    end
    check("rst_queue_left", exp_q.size(), 0);
    exp_q.delete();
    run_cmd(7, 8, 3, 3, BLUE, 0, 0, -1, 9, 11, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
